// File: rtl/led_pattern_gen.sv
// Eight-channel LED status driver: per-channel off/on/slow/fast blink modes,
// shared tick-based blink phases, and a timed lamp test that forces all LEDs green.
module led_pattern_gen #(
    parameter int TICK_DIV   = 100000,
    parameter int SLOW_HALF  = 500,
    parameter int FAST_HALF  = 125,
    parameter int TEST_TICKS = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [1:0] wr_data,
    input  logic       lamp_test,
    output logic [7:0] led,
    output logic       test_busy
);

    localparam int PW = $clog2(TICK_DIV);

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_ON   = 2'b01;
    localparam logic [1:0] MODE_SLOW = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

    typedef enum logic {IDLE, TEST} state_t;

    logic [PW-1:0] presc;
    logic          tick;
    logic [15:0]   slow_cnt;
    logic [15:0]   fast_cnt;
    logic          slow_phase;
    logic          fast_phase;
    logic [1:0]    mode [8];
    logic          lamp_prev;
    logic          lamp_edge;
    state_t        state;
    state_t        state_next;
    logic [15:0]   test_cnt;
    logic [7:0]    led_next;
    logic          busy_next;

    assign tick = (presc == PW'(TICK_DIV - 1));

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Blink phases are free-running so all channels of one rate stay in phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slow_cnt   <= '0;
            slow_phase <= 1'b0;
            fast_cnt   <= '0;
            fast_phase <= 1'b0;
        end else if (tick) begin
            if (slow_cnt == 16'(SLOW_HALF - 1)) begin
                slow_cnt   <= '0;
                slow_phase <= ~slow_phase;
            end else begin
                slow_cnt <= slow_cnt + 16'd1;
            end
            if (fast_cnt == 16'(FAST_HALF - 1)) begin
                fast_cnt   <= '0;
                fast_phase <= ~fast_phase;
            end else begin
                fast_cnt <= fast_cnt + 16'd1;
            end
        end
    end

    // NOTE: the mode array is small and must read as "off" after reset, so it
    // is built from resettable flops rather than a RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) mode[i] <= MODE_OFF;
        end else if (wr_en) begin
            mode[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lamp_prev <= 1'b0;
        end else begin
            lamp_prev <= lamp_test;
        end
    end

    assign lamp_edge = lamp_test & ~lamp_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (lamp_edge) state_next = TEST;
            TEST: if (tick && (test_cnt == 16'(TEST_TICKS - 1))) state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            test_cnt <= '0;
        end else if ((state == IDLE) && lamp_edge) begin
            test_cnt <= '0;
        end else if ((state == TEST) && tick) begin
            test_cnt <= test_cnt + 16'd1;
        end
    end

    // NOTE: every output of this comb block gets a default first, so no
    // path through the case/loop can infer a latch.
    always_comb begin
        busy_next = (state_next == TEST);
        led_next  = '0;
        if (busy_next) begin
            led_next = '1;
        end else begin
            for (int i = 0; i < 8; i++) begin
                case (mode[i])
                    MODE_OFF:  led_next[i] = 1'b0;
                    MODE_ON:   led_next[i] = 1'b1;
                    MODE_SLOW: led_next[i] = slow_phase;
                    MODE_FAST: led_next[i] = fast_phase;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led       <= '0;
            test_busy <= 1'b0;
        end else begin
            led       <= led_next;
            test_busy <= busy_next;
        end
    end

endmodule
